// File: rtl/sequence_player.sv
// Sly-Man-Says sequence player: drives light_up with timed colour flashes.
// Each element is lit for ON_CYCLES, then dark for OFF_CYCLES; done pulses at the end.
module sequence_player #(
  parameter int MAX_LEN    = 16,
  parameter int ON_CYCLES  = 25_000_000,
  parameter int OFF_CYCLES = 12_500_000,
  parameter int CNT_W      = 25,
  parameter int LEN_W      = 5
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [LEN_W-1:0]     seq_len,
  input  logic [2*MAX_LEN-1:0] seq_colors,
  output logic                 flash_led,
  output logic [1:0]           color,
  output logic                 on_off,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ON,
    S_OFF
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     timer_q, timer_d;
  logic [LEN_W-1:0]     idx_q, idx_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [2*MAX_LEN-1:0] colors_q, colors_d;
  logic                 flash_q, flash_d;
  logic [1:0]           color_q, color_d;
  logic                 on_off_q, on_off_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [LEN_W-1:0]     len_in;
  logic [LEN_W-1:0]     idx_nx;
  logic [2*MAX_LEN-1:0] shifted;

  assign len_in = (seq_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : seq_len;
  assign idx_nx = idx_q + LEN_W'(1);
  assign shifted = colors_q >> {idx_nx, 1'b0};

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    idx_d    = idx_q;
    len_d    = len_q;
    colors_d = colors_q;
    flash_d  = 1'b0;
    color_d  = color_q;
    on_off_d = on_off_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (start && !abort) begin
          colors_d = seq_colors;
          len_d    = len_in;
          if (len_in == '0) begin
            done_d = 1'b1;
          end else begin
            state_d  = S_ON;
            idx_d    = '0;
            timer_d  = '0;
            busy_d   = 1'b1;
            flash_d  = 1'b1;
            on_off_d = 1'b1;
            color_d  = seq_colors[1:0];
          end
        end
      end
      S_ON: begin
        if (abort) begin
          state_d  = S_IDLE;
          timer_d  = '0;
          idx_d    = '0;
          busy_d   = 1'b0;
          flash_d  = 1'b1;
          on_off_d = 1'b0;
        end else if (timer_q == CNT_W'(ON_CYCLES - 1)) begin
          state_d  = S_OFF;
          timer_d  = '0;
          flash_d  = 1'b1;
          on_off_d = 1'b0;
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end
      S_OFF: begin
        if (abort) begin
          state_d  = S_IDLE;
          timer_d  = '0;
          idx_d    = '0;
          busy_d   = 1'b0;
          flash_d  = 1'b1;
          on_off_d = 1'b0;
        end else if (timer_q == CNT_W'(OFF_CYCLES - 1)) begin
          timer_d = '0;
          // Compare idx+1 against len so len-1 never underflows.
          if (idx_nx < len_q) begin
            idx_d    = idx_nx;
            state_d  = S_ON;
            flash_d  = 1'b1;
            on_off_d = 1'b1;
            color_d  = shifted[1:0];
          end else begin
            state_d = S_IDLE;
            idx_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      timer_q  <= '0;
      idx_q    <= '0;
      len_q    <= '0;
      colors_q <= '0;
      flash_q  <= 1'b1;
      color_q  <= 2'd0;
      on_off_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      idx_q    <= idx_d;
      len_q    <= len_d;
      colors_q <= colors_d;
      flash_q  <= flash_d;
      color_q  <= color_d;
      on_off_q <= on_off_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign flash_led = flash_q;
  assign color     = color_q;
  assign on_off    = on_off_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_sequence_player.sv
// Bench for sequence_player: table of playback scenarios plus
// hand-written reset/abort sequences, checked cycle by cycle.
module tb_sequence_player;

  localparam int MAX_LEN = 16;
  localparam int ON      = 4;
  localparam int OFF     = 2;
  localparam int CNT_W   = 3;
  localparam int LEN_W   = 5;

  logic                 clock = 1'b0;
  logic                 reset = 1'b1;
  logic                 start = 1'b0;
  logic                 abort = 1'b0;
  logic [LEN_W-1:0]     seq_len = '0;
  logic [2*MAX_LEN-1:0] seq_colors = '0;
  logic                 flash_led;
  logic [1:0]           color;
  logic                 on_off;
  logic                 busy;
  logic                 done;

  always #5 clock = ~clock;

  sequence_player #(
    .MAX_LEN   (MAX_LEN),
    .ON_CYCLES (ON),
    .OFF_CYCLES(OFF),
    .CNT_W     (CNT_W),
    .LEN_W     (LEN_W)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .seq_len   (seq_len),
    .seq_colors(seq_colors),
    .flash_led (flash_led),
    .color     (color),
    .on_off    (on_off),
    .busy      (busy),
    .done      (done)
  );

  typedef struct {
    int         cyc;
    logic       on;
    logic [1:0] col;
    logic       dc;
  } ev_t;

  typedef struct {
    int          len;
    logic [31:0] colors;
    int          restart;
    int          abort_at;
  } vec_t;

  ev_t  exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   done_exp = -1;
  int   busy_lo = 1;
  int   busy_hi = 0;
  bit   mon_en = 1'b0;
  logic fexp;
  ev_t  head;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, want);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    if (mon_en) begin
      fexp = (exp_q.size() > 0) && (exp_q[0].cyc <= cyc);
      chk("flash", {31'd0, flash_led}, {31'd0, fexp});
      if (fexp) begin
        head = exp_q.pop_front();
        chk("flash_cyc", cyc, head.cyc);
        if (flash_led) begin
          chk("on_off", {31'd0, on_off}, {31'd0, head.on});
          if (!head.dc) chk("color", {30'd0, color}, {30'd0, head.col});
        end
      end
      chk("busy", {31'd0, busy}, {31'd0, (cyc >= busy_lo && cyc <= busy_hi)});
      chk("done", {31'd0, done}, {31'd0, (cyc == done_exp)});
    end
  end

  task automatic run(vec_t v);
    int t, n, a, last;
    ev_t e;
    t = cyc;
    n = (v.len > MAX_LEN) ? MAX_LEN : v.len;
    a = (v.abort_at > 0) ? t + v.abort_at : -1;
    for (int k = 0; k < n; k++) begin
      e.col = v.colors[2*k +: 2];
      e.dc  = 1'b0;
      e.cyc = t + 1 + k * (ON + OFF);
      e.on  = 1'b1;
      if (a < 0 || e.cyc <= a) exp_q.push_back(e);
      e.cyc = e.cyc + ON;
      e.on  = 1'b0;
      if (a < 0 || e.cyc <= a) exp_q.push_back(e);
    end
    if (a > 0) begin
      e.cyc = a + 1;
      e.on  = 1'b0;
      e.dc  = 1'b1;
      exp_q.push_back(e);
      done_exp = -1;
      busy_lo  = t + 1;
      busy_hi  = a;
      last     = a + 4;
    end else if (n == 0) begin
      done_exp = t + 1;
      busy_lo  = 1;
      busy_hi  = 0;
      last     = t + 4;
    end else begin
      done_exp = t + 1 + n * (ON + OFF);
      busy_lo  = t + 1;
      busy_hi  = done_exp - 1;
      last     = done_exp + 3;
    end
    seq_len    = LEN_W'(v.len);
    seq_colors = v.colors;
    start      = 1'b1;
    tick();
    start      = 1'b0;
    seq_colors = ~v.colors;
    seq_len    = 5'd7;
    while (cyc < last) begin
      if (v.restart > 0 && cyc == t + v.restart) start = 1'b1;
      if (a > 0 && cyc == a) abort = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
    end
    chk("queue_empty", exp_q.size(), 0);
    exp_q.delete();
  endtask

  vec_t tbl[7];

  initial begin
    tbl[0] = '{len: 3,  colors: 32'h0000_0032, restart: 0, abort_at: 0};
    tbl[1] = '{len: 0,  colors: 32'h0000_0032, restart: 0, abort_at: 0};
    tbl[2] = '{len: 3,  colors: 32'h0000_0032, restart: 0, abort_at: 8};
    tbl[3] = '{len: 3,  colors: 32'h0000_0032, restart: 3, abort_at: 0};
    tbl[4] = '{len: 20, colors: 32'hB4E1_27D8, restart: 0, abort_at: 0};
    tbl[5] = '{len: 1,  colors: 32'h0000_0003, restart: 0, abort_at: 6};
    tbl[6] = '{len: 16, colors: 32'h1B6C_93F0, restart: 0, abort_at: 0};

    reset = 1'b1;
    tick();
    tick();
    chk("rst_flash", {31'd0, flash_led}, 1);
    chk("rst_on_off", {31'd0, on_off}, 0);
    chk("rst_color", {30'd0, color}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    reset = 1'b0;
    tick();
    chk("post_rst_flash", {31'd0, flash_led}, 0);
    chk("post_rst_busy", {31'd0, busy}, 0);
    chk("post_rst_done", {31'd0, done}, 0);
    mon_en = 1'b1;

    for (int i = 0; i < 7; i++) run(tbl[i]);

    // abort together with start in IDLE: nothing may happen
    done_exp   = -1;
    busy_lo    = 1;
    busy_hi    = 0;
    seq_len    = 5'd3;
    seq_colors = 32'h0000_0032;
    start      = 1'b1;
    abort      = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    repeat (10) tick();

    // reset in the middle of playback
    mon_en = 1'b0;
    start  = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    reset = 1'b1;
    tick();
    chk("midrst_flash", {31'd0, flash_led}, 1);
    chk("midrst_on_off", {31'd0, on_off}, 0);
    chk("midrst_busy", {31'd0, busy}, 0);
    reset = 1'b0;
    tick();
    chk("midrst_rel_flash", {31'd0, flash_led}, 0);
    exp_q.delete();
    done_exp = -1;
    busy_lo  = 1;
    busy_hi  = 0;
    mon_en   = 1'b1;
    repeat (10) tick();
    run(tbl[0]);

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
